// File: rtl/axi4_lite_write_master_if.sv
// Core-side request/response and AXI4-lite AW/W/B signals of the write master.
// The master modport is the initiator view; slave is the client plus AXI-slave view.
interface axi4_lite_write_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [ADDR_W-1:0]     REQ_ADDR;
    logic [DATA_W-1:0]     REQ_DATA;
    logic [DATA_W/8-1:0]   REQ_STRB;
    logic                  RESP_VALID;
    logic                  RESP_READY;
    logic [1:0]            RESP_CODE;
    logic                  RESP_TMO;
    logic [ADDR_W-1:0]     AW_ADDR;
    logic                  AW_VALID;
    logic                  AW_READY;
    logic [DATA_W-1:0]     W_DATA;
    logic [DATA_W/8-1:0]   W_STRB;
    logic                  W_VALID;
    logic                  W_READY;
    logic [1:0]            B_RESP;
    logic                  B_VALID;
    logic                  B_READY;

    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_STRB, RESP_READY,
        input  AW_READY, W_READY, B_RESP, B_VALID,
        output REQ_READY, RESP_VALID, RESP_CODE, RESP_TMO,
        output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_STRB, RESP_READY,
        output AW_READY, W_READY, B_RESP, B_VALID,
        input  REQ_READY, RESP_VALID, RESP_CODE, RESP_TMO,
        input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY
    );
endinterface

// File: rtl/axi4_lite_write_master.sv
// Single-outstanding AXI4-lite write initiator: takes one client store, issues AW/W,
// collects B (or a forced SLVERR after TIMEOUT cycles) and hands it back to the client.
module axi4_lite_write_master #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input logic                      CLK,
    input logic                      RST,
    axi4_lite_write_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B, RESP} state_t;

    state_t              state_q, state_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_tmo_q, resp_tmo_d;
    logic [1:0]          resp_code_q, resp_code_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic req_ready, req_fire, aw_done, w_done, b_fire;

    assign req_ready = (state_q == IDLE) & ~RST;
    assign req_fire  = bus.REQ_VALID & req_ready;
    // A channel is done once its VALID has already dropped or its READY is seen now.
    assign aw_done   = ~aw_valid_q | bus.AW_READY;
    assign w_done    = ~w_valid_q | bus.W_READY;
    assign b_fire    = b_ready_q & bus.B_VALID;

    always_comb begin
        state_d      = state_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        resp_valid_d = resp_valid_q;
        resp_tmo_d   = resp_tmo_q;
        resp_code_d  = resp_code_q;
        aw_addr_d    = aw_addr_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    aw_addr_d  = bus.REQ_ADDR;
                    w_data_d   = bus.REQ_DATA;
                    w_strb_d   = bus.REQ_STRB;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                if (aw_valid_q & bus.AW_READY) aw_valid_d = 1'b0;
                if (w_valid_q & bus.W_READY)   w_valid_d  = 1'b0;
                if (aw_done & w_done) begin
                    b_ready_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                // A response arriving in the last allowed cycle beats the timeout.
                if (b_fire) begin
                    resp_code_d  = bus.B_RESP;
                    resp_tmo_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    b_ready_d    = 1'b0;
                    state_d      = RESP;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    resp_code_d  = 2'b10;
                    resp_tmo_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    b_ready_d    = 1'b0;
                    state_d      = RESP;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.RESP_READY) begin
                    resp_valid_d = 1'b0;
                    resp_tmo_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tmo_q   <= 1'b0;
            resp_code_q  <= 2'b00;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_tmo_q   <= resp_tmo_d;
            resp_code_q  <= resp_code_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.REQ_READY  = req_ready;
    assign bus.AW_ADDR    = aw_addr_q;
    assign bus.AW_VALID   = aw_valid_q;
    assign bus.W_DATA     = w_data_q;
    assign bus.W_STRB     = w_strb_q;
    assign bus.W_VALID    = w_valid_q;
    assign bus.B_READY    = b_ready_q;
    assign bus.RESP_VALID = resp_valid_q;
    assign bus.RESP_CODE  = resp_code_q;
    assign bus.RESP_TMO   = resp_tmo_q;
endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Bench for axi4_lite_write_master: table of directed transactions plus a random
// back-to-back run, all checked cycle by cycle against a transaction-level model.
module tb_axi4_lite_write_master;
    localparam int AW = 64, DW = 64, TMO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    axi4_lite_write_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    axi4_lite_write_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        bit          rdy_all;   // AW/W_READY tied high
        bit          bv_all;    // B_VALID tied high
        int          aw_d;      // AW_VALID cycles before AW_READY
        int          w_d;
        int          b_d;       // B_READY cycles before B_VALID (>=TMO: never)
        logic [1:0]  code;
        int          r_d;       // RESP_VALID cycles before RESP_READY
        logic [1:0]  exp_code;
        bit          exp_tmo;
        int          exp_lat;   // accept edge to first RESP_VALID, in cycles
    } vec_t;

    vec_t vt[8];
    int n_chk = 0, n_pass = 0;

    // transaction config and model state
    bit rdy_all, bv_all, rand_mode;
    int aw_d, w_d, b_d, r_d, rand_left;
    logic [1:0] b_code, exp_code;
    bit exp_tmo;
    bit busy, aw_done, w_done, b_done, resp_seen, acc_pending, req_go;
    int aw_wait, w_wait, b_wait, r_wait, lat, resp_lat;
    int n_acc, n_done, n_aw, n_w;
    logic [63:0] exp_addr, exp_data, nxt_addr, nxt_data;
    logic [7:0]  exp_strb, nxt_strb;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic rand_payload();
        nxt_addr = {$urandom, $urandom};
        nxt_data = {$urandom, $urandom};
        nxt_strb = 8'($urandom_range(0, 255));
    endtask

    task automatic accept();
        exp_addr = bus.REQ_ADDR;
        exp_data = bus.REQ_DATA;
        exp_strb = bus.REQ_STRB;
        if (rand_mode) begin
            aw_d     = $urandom_range(0, 3);
            w_d      = $urandom_range(0, 3);
            b_d      = $urandom_range(0, 10);
            r_d      = $urandom_range(0, 3);
            b_code   = 2'($urandom_range(0, 3));
            exp_tmo  = (b_d >= TMO);
            exp_code = exp_tmo ? 2'b10 : b_code;
            rand_left--;
        end
        busy = 1; aw_done = 0; w_done = 0; b_done = 0; resp_seen = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0; lat = 0;
        acc_pending = 1;
        n_acc++;
    endtask

    // One clock: check outputs against the model, drive inputs, then account for
    // the handshakes the coming rising edge will complete.
    task automatic cycle();
        bit was_busy;
        @(negedge CLK);
        if (busy) lat++;
        chk("req_ready", 64'(bus.REQ_READY), 64'(!busy));
        chk("aw_valid", 64'(bus.AW_VALID), 64'(busy && !aw_done));
        if (busy && !aw_done) chk("aw_addr", bus.AW_ADDR, exp_addr);
        chk("w_valid", 64'(bus.W_VALID), 64'(busy && !w_done));
        if (busy && !w_done) begin
            chk("w_data", bus.W_DATA, exp_data);
            chk("w_strb", 64'(bus.W_STRB), 64'(exp_strb));
        end
        chk("b_ready", 64'(bus.B_READY), 64'(busy && aw_done && w_done && !b_done));
        chk("resp_valid", 64'(bus.RESP_VALID), 64'(busy && b_done));
        chk("resp_tmo", 64'(bus.RESP_TMO), 64'(busy && b_done && exp_tmo));
        if (busy && b_done) begin
            chk("resp_code", 64'(bus.RESP_CODE), 64'(exp_code));
            if (!resp_seen) begin resp_seen = 1; resp_lat = lat; end
        end

        if (acc_pending) begin
            acc_pending = 0;
            if (rand_mode && rand_left > 0) begin
                rand_payload();
                bus.REQ_ADDR = nxt_addr; bus.REQ_DATA = nxt_data; bus.REQ_STRB = nxt_strb;
            end else bus.REQ_VALID = 1'b0;
        end
        if (req_go) begin
            req_go = 0;
            bus.REQ_VALID = 1'b1;
            bus.REQ_ADDR = nxt_addr; bus.REQ_DATA = nxt_data; bus.REQ_STRB = nxt_strb;
        end
        bus.AW_READY = rdy_all || (bus.AW_VALID && aw_wait >= aw_d);
        bus.W_READY  = rdy_all || (bus.W_VALID && w_wait >= w_d);
        if (bus.B_READY) bus.B_VALID = bv_all || (b_wait >= b_d);
        else bus.B_VALID = bv_all || (rand_mode && $urandom_range(0, 1) == 1);
        bus.B_RESP = b_code;
        bus.RESP_READY = bus.RESP_VALID && (r_wait >= r_d);

        was_busy = busy;
        if (bus.AW_VALID) aw_wait++;
        if (bus.W_VALID) w_wait++;
        if (bus.AW_VALID && bus.AW_READY) begin aw_done = 1; n_aw++; end
        if (bus.W_VALID && bus.W_READY) begin w_done = 1; n_w++; end
        if (bus.B_READY && bus.B_VALID) b_done = 1;
        else if (bus.B_READY && b_wait == TMO - 1) b_done = 1;
        if (bus.B_READY) b_wait++;
        if (bus.RESP_VALID) r_wait++;
        if (bus.RESP_VALID && bus.RESP_READY) begin busy = 0; n_done++; end
        if (bus.REQ_VALID && bus.REQ_READY) begin
            chk("no_overlap", 64'(was_busy), 64'(0));
            accept();
        end
    endtask

    task automatic start_vec(input vec_t v);
        rdy_all = v.rdy_all; bv_all = v.bv_all;
        aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; r_d = v.r_d; b_code = v.code;
        exp_code = v.exp_code; exp_tmo = v.exp_tmo;
        nxt_addr = v.addr; nxt_data = v.data; nxt_strb = v.strb;
        req_go = 1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        base = n_done;
        start_vec(v);
        for (int i = 0; i < 60 && n_done == base; i++) cycle();
        chk({tag, "_done"}, 64'(n_done), 64'(base + 1));
        chk({tag, "_lat"}, 64'(resp_lat), 64'(v.exp_lat));
    endtask

    initial begin
        vt[0] = '{64'h0000_0000_8000_0010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 1'b1, 0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 3};
        vt[1] = '{64'h0000_0000_1000_0040, 64'h01234567_89ABCDEF, 8'hF0, 1'b0, 1'b0, 0, 4, 0,  2'b01, 0, 2'b01, 1'b0, 7};
        vt[2] = '{64'h0000_0000_0000_2000, 64'h55AA55AA_55AA55AA, 8'h3C, 1'b0, 1'b0, 0, 0, 3,  2'b10, 4, 2'b10, 1'b0, 6};
        vt[3] = '{64'h0000_0000_0000_3000, 64'h11112222_33334444, 8'hFF, 1'b0, 1'b0, 0, 0, 99, 2'b00, 0, 2'b10, 1'b1, 10};
        vt[4] = '{64'h0000_0000_0000_4000, 64'hA5A5A5A5_5A5A5A5A, 8'h01, 1'b0, 1'b0, 0, 0, 7,  2'b11, 2, 2'b11, 1'b0, 10};
        vt[5] = '{64'h0000_0000_0000_5000, 64'h0F0F0F0F_F0F0F0F0, 8'h80, 1'b0, 1'b0, 0, 0, 8,  2'b01, 0, 2'b10, 1'b1, 10};
        vt[6] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 1'b0, 1'b0, 3, 0, 1,  2'b00, 1, 2'b00, 1'b0, 7};
        vt[7] = '{64'h0000_0000_0000_0000, 64'h00000000_00000000, 8'h00, 1'b0, 1'b0, 2, 2, 0,  2'b10, 0, 2'b10, 1'b0, 5};

        bus.REQ_VALID = 0; bus.REQ_ADDR = '0; bus.REQ_DATA = '0; bus.REQ_STRB = '0;
        bus.RESP_READY = 0; bus.AW_READY = 0; bus.W_READY = 0; bus.B_VALID = 0; bus.B_RESP = 2'b00;
        busy = 0; acc_pending = 0; req_go = 0; rand_mode = 0; rand_left = 0;
        n_acc = 0; n_done = 0; n_aw = 0; n_w = 0; resp_lat = -1;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", 64'(bus.REQ_READY), 64'(0));
        chk("rst_aw_valid", 64'(bus.AW_VALID), 64'(0));
        chk("rst_w_valid", 64'(bus.W_VALID), 64'(0));
        chk("rst_b_ready", 64'(bus.B_READY), 64'(0));
        chk("rst_resp_valid", 64'(bus.RESP_VALID), 64'(0));
        chk("rst_resp_tmo", 64'(bus.RESP_TMO), 64'(0));
        chk("rst_resp_code", 64'(bus.RESP_CODE), 64'(0));
        chk("rst_aw_addr", bus.AW_ADDR, 64'(0));
        chk("rst_w_data", bus.W_DATA, 64'(0));
        chk("rst_w_strb", 64'(bus.W_STRB), 64'(0));
        RST = 1'b0;
        #1 chk("post_rst_req_ready", 64'(bus.REQ_READY), 64'(1));

        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // asynchronous reset while both channels are still waiting for READY
        begin
            vec_t va;
            va = vt[1];
            va.aw_d = 20; va.w_d = 20;
            start_vec(va);
            repeat (4) cycle();
            #2 RST = 1'b1;
            #1;
            chk("midrst_aw_valid", 64'(bus.AW_VALID), 64'(0));
            chk("midrst_w_valid", 64'(bus.W_VALID), 64'(0));
            chk("midrst_req_ready", 64'(bus.REQ_READY), 64'(0));
            bus.REQ_VALID = 0; bus.AW_READY = 0; bus.W_READY = 0; bus.B_VALID = 0; bus.RESP_READY = 0;
            busy = 0; acc_pending = 0; req_go = 0;
            repeat (2) @(negedge CLK);
            RST = 1'b0;
            #1 chk("midrst_rel_req_ready", 64'(bus.REQ_READY), 64'(1));
            chk("midrst_aw_addr", bus.AW_ADDR, 64'(0));
            run_vec(vt[0], "after_rst");
        end

        // 16 back-to-back random requests with random stalls and occasional timeouts
        begin
            int b_done0, b_aw0, b_w0, b_acc0;
            b_done0 = n_done; b_aw0 = n_aw; b_w0 = n_w; b_acc0 = n_acc;
            rand_mode = 1; rand_left = 16; rdy_all = 0; bv_all = 0;
            rand_payload();
            req_go = 1;
            for (int i = 0; i < 1000 && n_done < b_done0 + 16; i++) cycle();
            repeat (3) cycle();
            chk("rand_accepts", 64'(n_acc - b_acc0), 64'(16));
            chk("rand_aw_hs", 64'(n_aw - b_aw0), 64'(16));
            chk("rand_w_hs", 64'(n_w - b_w0), 64'(16));
            chk("rand_resps", 64'(n_done - b_done0), 64'(16));
            rand_mode = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
